// File: rtl/nes_capture_pkg.sv
// Shared types and constants for the NES pixel capture block.
// Imported by the capture top level.
package nes_capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        CAPTURE,
        DROP
    } capture_state_t;

    localparam int PIX_PER_WORD = 4;
    localparam int WORD_W       = 32;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO.
// A pop on a full FIFO frees the slot for a same-edge push.
module sync_fifo_fwft #(
    parameter int DW    = 34,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Gate the read port so the output is all-zero whenever nothing is held.
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/nes_pixel_capture.sv
// Packs the NES PPU pixel stream into 32-bit words with
// start-of-frame / end-of-line markers on a valid/ready stream.
module nes_pixel_capture
    import nes_capture_pkg::*;
#(
    parameter int WIDTH      = 256,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  pixel,
    input  logic        pixel_en,
    input  logic        vblank,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_sof,
    output logic        m_eol,
    output logic [15:0] frame_cnt,
    output logic        overflow,
    output logic        sync_err
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int LW = $clog2(PIX_PER_WORD);
    localparam int FW = WORD_W + 2;
    localparam int PW = WORD_W - 8;

    localparam logic [XW-1:0] X_LAST    = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(HEIGHT - 1);
    localparam logic [LW-1:0] LANE_LAST = LW'(PIX_PER_WORD - 1);

    capture_state_t state_q, state_d;

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [PW-1:0] pack_q;
    logic          sof_pend_q;
    logic          vb_q;
    logic          push_q;
    logic          last_q;
    logic [FW-1:0] word_q;
    logic [15:0]   frame_q;
    logic          ovf_q;
    logic          serr_q;

    logic          fifo_full;
    logic          fifo_empty;
    logic [FW-1:0] fifo_dout;
    logic          pop;

    logic          vb_fall;
    logic          vb_rise;
    logic          drop;
    logic [LW-1:0] lane;
    logic          eol_px;
    logic          eof_px;

    logic          take;
    logic          start;
    logic          clr_sticky;
    logic          set_serr;

    assign vb_fall = vb_q & ~vblank;
    assign vb_rise = ~vb_q & vblank;
    assign pop     = ~fifo_empty & m_ready;
    assign drop    = push_q & fifo_full & ~pop;
    assign lane    = x_q[LW-1:0];
    assign eol_px  = (x_q == X_LAST);
    assign eof_px  = eol_px && (y_q == Y_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = ARM;
            ARM: begin
                if (drop)         state_d = DROP;
                else if (vb_fall) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (vb_rise)     state_d = ARM;
                else if (drop)   state_d = DROP;
                else if (take && eof_px) state_d = ARM;
            end
            DROP: begin
                if (vb_fall) state_d = CAPTURE;
            end
            default: state_d = IDLE;
        endcase
        if (!en) state_d = IDLE;
    end

    always_comb begin
        take       = 1'b0;
        start      = 1'b0;
        clr_sticky = 1'b0;
        set_serr   = 1'b0;
        unique case (state_q)
            IDLE: clr_sticky = en;
            ARM:  start = en & vb_fall & ~drop;
            CAPTURE: begin
                set_serr = en & vb_rise;
                take     = en & ~vb_rise & ~drop & pixel_en;
            end
            DROP: start = en & vb_fall;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q        <= '0;
            y_q        <= '0;
            pack_q     <= '0;
            sof_pend_q <= 1'b0;
            vb_q       <= 1'b1;
            push_q     <= 1'b0;
            last_q     <= 1'b0;
            word_q     <= '0;
        end else begin
            vb_q   <= vblank;
            push_q <= 1'b0;
            if (start) begin
                x_q        <= '0;
                y_q        <= '0;
                sof_pend_q <= 1'b1;
            end
            if (take) begin
                for (int i = 0; i < PIX_PER_WORD - 1; i++) begin
                    if (lane == LW'(i)) pack_q[8*i +: 8] <= pixel;
                end
                if (lane == LANE_LAST) begin
                    push_q     <= 1'b1;
                    word_q     <= {sof_pend_q, eol_px, pixel, pack_q};
                    last_q     <= eof_px;
                    sof_pend_q <= 1'b0;
                end
                if (eol_px) begin
                    x_q <= '0;
                    y_q <= y_q + 1'b1;
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end
        end
    end

    // Frame count and stickies follow the push edge, one clock after sampling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
            ovf_q   <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            if (push_q && !drop && last_q) frame_q <= frame_q + 16'd1;
            if (drop)            ovf_q <= 1'b1;
            else if (clr_sticky) ovf_q <= 1'b0;
            if (set_serr)        serr_q <= 1'b1;
            else if (clr_sticky) serr_q <= 1'b0;
        end
    end

    sync_fifo_fwft #(
        .DW    (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_q),
        .pop   (pop),
        .din   (word_q),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign m_valid   = ~fifo_empty;
    assign m_data    = fifo_dout[WORD_W-1:0];
    assign m_eol     = fifo_dout[WORD_W];
    assign m_sof     = fifo_dout[WORD_W+1];
    assign frame_cnt = frame_q;
    assign overflow  = ovf_q;
    assign sync_err  = serr_q;

endmodule

// File: tb/tb_nes_pixel_capture.sv
// Directed + randomized bench for nes_pixel_capture.
// Expected words come from a pixel-index model of each frame.
module tb_nes_pixel_capture;

    localparam int W = 16;
    localparam int H = 4;
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  pixel = 8'h00;
    logic        pixel_en = 1'b0;
    logic        vblank = 1'b1;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_sof;
    logic        m_eol;
    logic [15:0] frame_cnt;
    logic        overflow;
    logic        sync_err;

    always #5 clk = ~clk;

    nes_pixel_capture #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .FIFO_DEPTH (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .pixel     (pixel),
        .pixel_en  (pixel_en),
        .vblank    (vblank),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_sof     (m_sof),
        .m_eol     (m_eol),
        .frame_cnt (frame_cnt),
        .overflow  (overflow),
        .sync_err  (sync_err)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [33:0] q[$];
    int          k = 0;
    logic [31:0] word = '0;
    int          exp_frames = 0;
    int          ready_mode = 0;
    logic        tog = 1'b1;
    logic        hold = 1'b0;

    task automatic chk(input string tag, input logic [33:0] obs,
                       input logic [33:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive m_ready, check the stream, then advance one clock.
    task automatic tick();
        case (ready_mode)
            0: m_ready = 1'b1;
            1: m_ready = ($urandom_range(3) != 0);
            2: begin m_ready = tog; tog = ~tog; end
            default: m_ready = 1'b0;
        endcase
        if (hold) chk("hold_valid", m_valid, 1);
        if (m_valid) begin
            chk("q_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
                chk("word", {m_sof, m_eol, m_data}, q[0]);
                if (m_ready) void'(q.pop_front());
            end
        end
        hold = m_valid && !m_ready;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_pix(input logic [7:0] v);
        word[8*(k%4) +: 8] = v;
        if (k % 4 == 3) q.push_back({k == 3, (k % W) == W - 1, word});
        k++;
    endtask

    task automatic drive_pix(input logic [7:0] v);
        pixel = v;
        pixel_en = 1'b1;
        model_pix(v);
        tick();
        pixel_en = 1'b0;
    endtask

    task automatic start_frame();
        pixel_en = 1'b0;
        vblank = 1'b1;
        repeat (3) tick();
        vblank = 1'b0;
        tick();
        k = 0;
    endtask

    task automatic run_frame(input int gap);
        start_frame();
        for (int i = 0; i < W * H; i++) begin
            while ($urandom_range(99) < gap) tick();
            drive_pix(8'($urandom_range(255)));
        end
        tick();
        exp_frames++;
        chk("frame_cnt", frame_cnt, exp_frames);
        pixel = 8'($urandom_range(255));
        pixel_en = 1'b1;
        repeat (4) tick();
        pixel_en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && q.size() != 0; i++) tick();
        chk("drained", q.size(), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_flags", {m_valid, m_sof, m_eol, overflow, sync_err}, 0);
        chk("rst_data", m_data, 0);
        chk("rst_frame", frame_cnt, 0);
        rst_n = 1'b1;
        en = 1'b1;
        tick();

        // Latency with a 1010 consumer
        ready_mode = 2;
        start_frame();
        for (int i = 0; i < 4; i++) drive_pix(8'(i * 3 + 1));
        chk("lat_n", m_valid, 0);
        tick();
        chk("lat_n1", m_valid, 1);
        for (int i = 4; i < W * H; i++) drive_pix(8'(((i % W) + (i / W)) & 8'hff));
        tick();
        exp_frames++;
        chk("frame_cnt", frame_cnt, exp_frames);
        drain();

        // Random pixel gaps, random consumer
        ready_mode = 1;
        repeat (3) run_frame(30);
        drain();
        chk("no_stickies", {overflow, sync_err}, 0);

        // Push and pop on the same edge while full
        ready_mode = 3;
        start_frame();
        for (int i = 0; i < 36; i++) drive_pix(8'($urandom_range(255)));
        ready_mode = 0;
        tick();
        chk("full_pushpop", overflow, 0);
        for (int i = 36; i < W * H; i++) drive_pix(8'($urandom_range(255)));
        tick();
        exp_frames++;
        chk("frame_cnt", frame_cnt, exp_frames);
        drain();

        // Overflow: ninth word is dropped, rest of frame ignored
        ready_mode = 3;
        start_frame();
        for (int i = 0; i < 35; i++) drive_pix(8'($urandom_range(255)));
        drive_pix(8'hA5);
        chk("ovf_n", overflow, 0);
        tick();
        chk("ovf_n1", overflow, 1);
        pixel_en = 1'b1;
        repeat (20) tick();
        pixel_en = 1'b0;
        while (q.size() > D) void'(q.pop_back());
        ready_mode = 0;
        drain();
        chk("ovf_frame", frame_cnt, exp_frames);
        run_frame(0);
        drain();
        chk("ovf_sticky", {overflow, sync_err}, 2'b10);

        // Short line: vblank rises mid-line
        ready_mode = 1;
        start_frame();
        for (int i = 0; i < 2 * W + 6; i++) drive_pix(8'($urandom_range(255)));
        vblank = 1'b1;
        tick();
        tick();
        chk("sync_err", sync_err, 1);
        chk("short_frame", frame_cnt, exp_frames);
        drain();
        run_frame(20);
        drain();

        // en toggle clears stickies
        en = 1'b0;
        tick();
        chk("sticky_held", {overflow, sync_err}, 2'b11);
        en = 1'b1;
        tick();
        chk("sticky_clr", {overflow, sync_err}, 0);
        run_frame(0);
        drain();

        // en falls mid-frame: partial word lost, FIFO drains
        ready_mode = 0;
        start_frame();
        for (int i = 0; i < 21; i++) drive_pix(8'($urandom_range(255)));
        en = 1'b0;
        tick();
        pixel_en = 1'b1;
        repeat (4) tick();
        pixel_en = 1'b0;
        drain();
        chk("en_fall_frame", frame_cnt, exp_frames);
        en = 1'b1;
        tick();
        run_frame(10);
        drain();

        // Asynchronous reset mid-frame
        ready_mode = 1;
        start_frame();
        for (int i = 0; i < 14; i++) drive_pix(8'($urandom_range(255)));
        #3 rst_n = 1'b0;
        #1;
        chk("arst_flags", {m_valid, m_sof, m_eol, overflow, sync_err}, 0);
        chk("arst_data", m_data, 0);
        chk("arst_frame", frame_cnt, 0);
        q.delete();
        hold = 1'b0;
        exp_frames = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_frame(10);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
